simd_alu_256: RTL and testbench
===============================

Name: simd_alu_256

Overview:
- Registered, lane-parallel (SIMD) ALU for the vector datapath of the RISC-V processing element.
- Splits two 256-bit operands into NUM_REGS independent ELEM_WIDTH-bit lanes and applies one operation, selected by a 3-bit code, to every lane.
- Registers the 256-bit result and per-lane Zero/Negative/Carry/Overflow flags, giving one cycle of latency.

Parameters:
- NUM_REGS, 8, number of lanes.
- REG_WIDTH, 256, total operand/result width; must equal NUM_REGS*ELEM_WIDTH.
- ELEM_WIDTH, 32, lane width in bits.

Ports:
- clk  in  1  single clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and control valid this cycle.
- A  in  REG_WIDTH  operand A; lane i = A[i*ELEM_WIDTH +: ELEM_WIDTH]; lane 0 is least significant.
- B  in  REG_WIDTH  operand B, same lane mapping.
- ALUControl  in  3  operation select.
- out_valid  out  1  Result and flags hold a new value.
- Result  out  REG_WIDTH  lane results, same lane mapping.
- OverFlow  out  NUM_REGS  bit i = signed overflow of lane i.
- Carry  out  NUM_REGS  bit i = carry / no-borrow of lane i.
- Zero  out  NUM_REGS  bit i = lane i result is all zero.
- Negative  out  NUM_REGS  bit i = MSB of lane i result.

Behaviour:
- Reset (rst_n low, asynchronous): Result, all flag vectors and out_valid clear to 0 immediately and stay 0 while rst_n is low.
- Capture: on each rising clk with in_valid=1, register the lane results and flags of the current inputs and set out_valid=1. Latency is exactly 1 cycle; a new operation may be issued every cycle.
- Hold: with in_valid=0, out_valid drops to 0 on the next edge, and Result and flags hold their last values.
- Operations, per lane a, b (ELEM_WIDTH bits each):
  - 000 ADD: a+b, wraps modulo 2^ELEM_WIDTH.
  - 001 SUB: a-b, wraps modulo 2^ELEM_WIDTH.
  - 010 AND: a&b.
  - 011 OR: a|b.
  - 100 SLL: a << b[4:0] (log2(ELEM_WIDTH) low bits of b); zeros fill from the right.
  - 101 SLT: 1 if signed(a) < signed(b), else 0; result is zero-extended to the lane width.
  - 110 XOR: a^b.
  - 111 SRL: a >> b[4:0], logical.
- Carry:
  - ADD: carry-out of the lane adder.
  - SUB: computed as a + ~b + 1; Carry=1 means no borrow (a >= b unsigned).
  - All other ops: 0.
- OverFlow:
  - ADD: a, b same sign and result sign differs.
  - SUB: a, b signs differ and result sign differs from a.
  - All other ops: 0.
- Zero and Negative: computed from the final lane result for every operation.
- Lane isolation: carries never propagate across lane boundaries.

Test Plan:
- Shared vectors for the scenarios below:
  - A = 00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008
  - B = 00000009_00000007_00000006_00000005_00000004_00000003_00000002_00000001
- ADD (000), one cycle after in_valid -> Result = 0000000A_00000009_00000009_00000009_00000009_00000009_00000009_00000009; all flags 00.
- SUB (001) -> Result = FFFFFFF8_FFFFFFFB_FFFFFFFD_FFFFFFFF_00000001_00000003_00000005_00000007; Negative = F0, Carry = 0F, Zero = 00, OverFlow = 00.
- AND (010) -> Result = 00000001_00000002_00000002_00000004_00000004_00000002_00000002_00000000; Zero = 01.
- OR (011) -> Result = 00000009_00000007_00000007_00000005_00000005_00000007_00000007_00000009.
- SLL (100) -> Result = 00000200_00000100_000000C0_00000080_00000050_00000030_0000001C_00000010.
- SLT (101) -> Result = 00000001 in the upper 4 lanes, 00000000 in the lower 4 lanes; Zero = 0F.
- Edge cases, all lanes A = 7FFFFFFF, B = 00000001:
  - ADD -> every lane 80000000, OverFlow = FF, Negative = FF.
  - A = FFFFFFFF, B = 00000001, ADD -> every lane 0, Carry = FF, Zero = FF.
- Reset: assert rst_n = 0 mid-stream (between clock edges) -> Result, flags and out_valid read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/simd_alu_256_if.sv
`default_nettype none
// ============================================================================
// Module   : simd_alu_256_if
// Brief    : Operand/control and result/flag bundle for the lane-parallel ALU.
// Revision : 1.0 - initial release
// ============================================================================
interface simd_alu_256_if #(
  parameter int NUM_REGS   = 8,
  parameter int ELEM_WIDTH = 32,
  parameter int REG_WIDTH  = NUM_REGS * ELEM_WIDTH
);
  logic                 in_valid;
  logic [REG_WIDTH-1:0] A;
  logic [REG_WIDTH-1:0] B;
  logic [2:0]           ALUControl;

  logic                 out_valid;
  logic [REG_WIDTH-1:0] Result;
  logic [NUM_REGS-1:0]  OverFlow;
  logic [NUM_REGS-1:0]  Carry;
  logic [NUM_REGS-1:0]  Zero;
  logic [NUM_REGS-1:0]  Negative;

  modport master (
    output in_valid, A, B, ALUControl,
    input  out_valid, Result, OverFlow, Carry, Zero, Negative
  );

  modport slave (
    input  in_valid, A, B, ALUControl,
    output out_valid, Result, OverFlow, Carry, Zero, Negative
  );
endinterface
`default_nettype wire

// File: rtl/simd_alu_256.sv
`default_nettype none
// ============================================================================
// Module   : simd_alu_256
// Brief    : Registered SIMD ALU; one op applied to every lane, 1-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module simd_alu_256 #(
  parameter int NUM_REGS   = 8,
  parameter int REG_WIDTH  = 256,
  parameter int ELEM_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  simd_alu_256_if.slave     bus
);
  localparam int SHAMT_W = $clog2(ELEM_WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  logic [REG_WIDTH-1:0] lane_result;
  logic [NUM_REGS-1:0]  lane_ov;
  logic [NUM_REGS-1:0]  lane_c;
  logic [NUM_REGS-1:0]  lane_z;
  logic [NUM_REGS-1:0]  lane_n;

  logic                 out_valid_d, out_valid_q;
  logic [REG_WIDTH-1:0] result_d,    result_q;
  logic [NUM_REGS-1:0]  overflow_d,  overflow_q;
  logic [NUM_REGS-1:0]  carry_d,     carry_q;
  logic [NUM_REGS-1:0]  zero_d,      zero_q;
  logic [NUM_REGS-1:0]  negative_d,  negative_q;

  genvar i;
  generate
    for (i = 0; i < NUM_REGS; i++) begin : g_lane
      logic [ELEM_WIDTH-1:0] a;
      logic [ELEM_WIDTH-1:0] b;
      logic [ELEM_WIDTH-1:0] r;
      logic [ELEM_WIDTH:0]   sum;
      logic [ELEM_WIDTH:0]   diff;
      logic [SHAMT_W-1:0]    shamt;
      logic                  c;
      logic                  ov;

      assign a     = bus.A[i*ELEM_WIDTH +: ELEM_WIDTH];
      assign b     = bus.B[i*ELEM_WIDTH +: ELEM_WIDTH];
      // Each lane has its own adder, so no carry can leak into the next lane.
      assign sum   = {1'b0, a} + {1'b0, b};
      assign diff  = {1'b0, a} + {1'b0, ~b} + {{ELEM_WIDTH{1'b0}}, 1'b1};
      assign shamt = b[SHAMT_W-1:0];

      always_comb begin
        r  = '0;
        c  = 1'b0;
        ov = 1'b0;
        case (bus.ALUControl)
          OP_ADD: begin
            r  = sum[ELEM_WIDTH-1:0];
            c  = sum[ELEM_WIDTH];
            ov = (a[ELEM_WIDTH-1] == b[ELEM_WIDTH-1]) &&
                 (sum[ELEM_WIDTH-1] != a[ELEM_WIDTH-1]);
          end
          OP_SUB: begin
            r  = diff[ELEM_WIDTH-1:0];
            c  = diff[ELEM_WIDTH];
            ov = (a[ELEM_WIDTH-1] != b[ELEM_WIDTH-1]) &&
                 (diff[ELEM_WIDTH-1] != a[ELEM_WIDTH-1]);
          end
          OP_AND:  r = a & b;
          OP_OR:   r = a | b;
          OP_SLL:  r = a << shamt;
          OP_SLT:  r = {{(ELEM_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
          OP_XOR:  r = a ^ b;
          OP_SRL:  r = a >> shamt;
          default: r = '0;
        endcase
      end

      assign lane_result[i*ELEM_WIDTH +: ELEM_WIDTH] = r;
      assign lane_c[i]  = c;
      assign lane_ov[i] = ov;
      assign lane_z[i]  = (r == '0);
      assign lane_n[i]  = r[ELEM_WIDTH-1];
    end
  endgenerate

  // Idle cycles keep the last result and flags visible.
  always_comb begin
    out_valid_d = bus.in_valid;
    result_d    = result_q;
    overflow_d  = overflow_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    negative_d  = negative_q;
    if (bus.in_valid) begin
      result_d   = lane_result;
      overflow_d = lane_ov;
      carry_d    = lane_c;
      zero_d     = lane_z;
      negative_d = lane_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= '0;
      carry_q     <= '0;
      zero_q      <= '0;
      negative_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      negative_q  <= negative_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.Result    = result_q;
  assign bus.OverFlow  = overflow_q;
  assign bus.Carry     = carry_q;
  assign bus.Zero      = zero_q;
  assign bus.Negative  = negative_q;
endmodule
`default_nettype wire

// File: tb/tb_simd_alu_256.sv
`default_nettype none
// ============================================================================
// Module   : tb_simd_alu_256
// Brief    : Directed vector bench for simd_alu_256.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simd_alu_256;
  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] res;
    logic [7:0]   ov;
    logic [7:0]   c;
    logic [7:0]   z;
    logic [7:0]   n;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  simd_alu_256_if #(.NUM_REGS(8), .ELEM_WIDTH(32), .REG_WIDTH(256)) bus ();

  simd_alu_256 #(.NUM_REGS(8), .REG_WIDTH(256), .ELEM_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] rep(input logic [31:0] x);
    return {8{x}};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic v, input vec_t e);
    chk({name, ".valid"}, {255'd0, bus.out_valid}, {255'd0, v});
    chk({name, ".res"},   bus.Result, e.res);
    chk({name, ".ov"},    {248'd0, bus.OverFlow}, {248'd0, e.ov});
    chk({name, ".c"},     {248'd0, bus.Carry},    {248'd0, e.c});
    chk({name, ".z"},     {248'd0, bus.Zero},     {248'd0, e.z});
    chk({name, ".n"},     {248'd0, bus.Negative}, {248'd0, e.n});
  endtask

  vec_t vecs[15];
  vec_t zero_v;
  logic [255:0] sa, sb;

  initial begin
    checks = 0;
    errors = 0;
    sa = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;
    sb = 256'h00000009_00000007_00000006_00000005_00000004_00000003_00000002_00000001;

    vecs[0]  = '{"add",  3'b000, sa, sb,
                 256'h0000000A_00000009_00000009_00000009_00000009_00000009_00000009_00000009,
                 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{"sub",  3'b001, sa, sb,
                 256'hFFFFFFF8_FFFFFFFB_FFFFFFFD_FFFFFFFF_00000001_00000003_00000005_00000007,
                 8'h00, 8'h0F, 8'h00, 8'hF0};
    vecs[2]  = '{"and",  3'b010, sa, sb,
                 256'h00000001_00000002_00000002_00000004_00000004_00000002_00000002_00000000,
                 8'h00, 8'h00, 8'h01, 8'h00};
    vecs[3]  = '{"or",   3'b011, sa, sb,
                 256'h00000009_00000007_00000007_00000005_00000005_00000007_00000007_00000009,
                 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[4]  = '{"sll",  3'b100, sa, sb,
                 256'h00000200_00000100_000000C0_00000080_00000050_00000030_0000001C_00000010,
                 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[5]  = '{"slt",  3'b101, sa, sb,
                 256'h00000001_00000001_00000001_00000001_00000000_00000000_00000000_00000000,
                 8'h00, 8'h00, 8'h0F, 8'h00};
    vecs[6]  = '{"xor",  3'b110, sa, sb,
                 256'h00000008_00000005_00000005_00000001_00000001_00000005_00000005_00000009,
                 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[7]  = '{"srl",  3'b111, sa, sb,
                 256'h00000000_00000000_00000000_00000000_00000000_00000000_00000001_00000004,
                 8'h00, 8'h00, 8'hFC, 8'h00};
    vecs[8]  = '{"add_ovf", 3'b000, rep(32'h7FFFFFFF), rep(32'h00000001),
                 rep(32'h80000000), 8'hFF, 8'h00, 8'h00, 8'hFF};
    vecs[9]  = '{"add_carry", 3'b000, rep(32'hFFFFFFFF), rep(32'h00000001),
                 rep(32'h00000000), 8'h00, 8'hFF, 8'hFF, 8'h00};
    vecs[10] = '{"sub_eq", 3'b001, rep(32'h12345678), rep(32'h12345678),
                 rep(32'h00000000), 8'h00, 8'hFF, 8'hFF, 8'h00};
    vecs[11] = '{"sub_ovf", 3'b001, rep(32'h80000000), rep(32'h00000001),
                 rep(32'h7FFFFFFF), 8'hFF, 8'hFF, 8'h00, 8'h00};
    vecs[12] = '{"sll_mask", 3'b100, rep(32'h00000001), rep(32'h00000021),
                 rep(32'h00000002), 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[13] = '{"slt_signed", 3'b101, rep(32'hFFFFFFFF), rep(32'h00000001),
                 rep(32'h00000001), 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[14] = '{"srl_logic", 3'b111, rep(32'h80000000), rep(32'h0000001F),
                 rep(32'h00000001), 8'h00, 8'h00, 8'h00, 8'h00};
    zero_v   = '{"zero", 3'b000, '0, '0, '0, 8'h00, 8'h00, 8'h00, 8'h00};

    bus.in_valid   = 1'b0;
    bus.A          = '0;
    bus.B          = '0;
    bus.ALUControl = 3'b000;
    rst_n          = 1'b0;
    #1;
    chk_all("reset", 1'b0, zero_v);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back issue: a new vector every cycle.
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      bus.in_valid   = 1'b1;
      bus.A          = vecs[k].a;
      bus.B          = vecs[k].b;
      bus.ALUControl = vecs[k].op;
      @(posedge clk);
      #1;
      chk_all(vecs[k].name, 1'b1, vecs[k]);
    end

    // Idle cycle: valid drops, last result and flags hold.
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.A          = sa;
    bus.B          = sb;
    bus.ALUControl = 3'b000;
    @(posedge clk);
    #1;
    chk_all("hold", 1'b0, vecs[14]);

    // Re-issue, then assert reset between edges.
    @(negedge clk);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk_all("reissue", 1'b1, vecs[0]);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, zero_v);
    @(posedge clk);
    #1;
    chk_all("rst_held", 1'b0, zero_v);
    @(negedge clk);
    rst_n = 1'b1;
    bus.ALUControl = 3'b001;
    @(posedge clk);
    #1;
    chk_all("post_rst", 1'b1, vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
